// File: rtl/ex_alu_unit.sv
// ex_alu_unit: registered RV32I execute-stage ALU with valid/ready in, stall/flush out.
// Define SERIAL_SHIFT_EN for an iterative 1-bit-per-cycle shifter instead of a barrel.
module ex_alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      in_rd,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_zero
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q;
  state_t          state_d;
  logic            accept;
  logic            can_load;
  logic [4:0]      shamt;
  logic [XLEN-1:0] res;
  logic            cmp_valid;
  logic [XLEN-1:0] cmp_result;
  logic [4:0]      cmp_rd;

  assign shamt    = src_b[4:0];
  assign can_load = ~out_valid | ~stall;
  assign in_ready = (state_q == IDLE) & can_load & ~flush;
  assign accept   = in_valid & in_ready;

  // Single-cycle result for every code; reserved codes yield zero.
  always_comb begin
    res = '0;
    unique case (alu_ctrl)
      4'b0000: res = src_a + src_b;
      4'b0001: res = src_a + ~src_b + 1'b1;
      4'b0010: res = src_a & src_b;
      4'b0011: res = src_a | src_b;
      4'b0100: res = src_a ^ src_b;
      4'b0101: res = src_a << shamt;
      4'b0110: res = src_a >> shamt;
      4'b0111: res = $signed(src_a) >>> shamt;
      4'b1000: res = {{(XLEN-1){1'b0}},
                      $signed(src_a) < $signed(src_b)};
      4'b1001: res = {{(XLEN-1){1'b0}},
                      src_a < src_b};
      default: res = '0;
    endcase
  end

`ifdef SERIAL_SHIFT_EN
  logic [XLEN-1:0] work_q;
  logic [XLEN-1:0] work_d;
  logic [XLEN-1:0] step;
  logic [4:0]      cnt_q;
  logic [4:0]      cnt_d;
  logic [1:0]      sop_q;
  logic [1:0]      sop_d;
  logic [4:0]      rd_q;
  logic [4:0]      rd_d;
  logic            is_shift;
  logic            go;
  logic            done;

  assign is_shift = (alu_ctrl == 4'b0101) |
                    (alu_ctrl == 4'b0110) |
                    (alu_ctrl == 4'b0111);

  // One-bit step of the working register; low ctrl bits pick the shift kind.
  always_comb begin
    step = work_q;
    unique case (sop_q)
      2'b01:   step = work_q << 1;
      2'b10:   step = work_q >> 1;
      default: step = {work_q[XLEN-1], work_q[XLEN-1:1]};
    endcase
  end

  // Next state: launch nonzero shifts, count down, finish when output is free.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    rd_d    = rd_q;
    go      = 1'b0;
    done    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept && is_shift && shamt != 5'd0) begin
            go      = 1'b1;
            state_d = SHIFT;
            work_d  = src_a;
            cnt_d   = shamt;
            sop_d   = alu_ctrl[1:0];
            rd_d    = in_rd;
          end
        end
        SHIFT: begin
          if (cnt_q == 5'd1) begin
            if (can_load) begin
              done    = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
              work_d  = step;
            end
          end else begin
            work_d = step;
            cnt_d  = cnt_q - 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Iterative shifter working registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_q <= '0;
      cnt_q  <= '0;
      sop_q  <= '0;
      rd_q   <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      sop_q  <= sop_d;
      rd_q   <= rd_d;
    end
  end

  assign cmp_valid  = (accept & ~go) | done;
  assign cmp_result = done ? step : res;
  assign cmp_rd     = done ? rd_q : in_rd;
`else
  // Barrel shifter covers every op, so the machine never leaves IDLE.
  always_comb begin
    state_d = IDLE;
  end

  assign cmp_valid  = accept;
  assign cmp_result = res;
  assign cmp_rd     = in_rd;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Output register: flush kills, completion loads, drain clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_zero   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (cmp_valid) begin
      out_valid  <= 1'b1;
      out_result <= cmp_result;
      out_rd     <= cmp_rd;
      out_zero   <= (cmp_result == '0);
    end else if (!stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: directed and randomized checks of ex_alu_unit
// against an arithmetic reference model.
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  in_rd;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_zero;

  int passed = 0;
  int total  = 0;

  ex_alu_unit #(.XLEN(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_ctrl(alu_ctrl),
    .src_a(src_a),
    .src_b(src_b),
    .in_rd(in_rd),
    .stall(stall),
    .flush(flush),
    .out_valid(out_valid),
    .out_result(out_result),
    .out_rd(out_rd),
    .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [3:0]  c,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] p;
    logic [63:0] q;
    int sh;
    sh = int'(b % 32);
    p = 64'd1;
    for (int k = 0; k < sh; k++) p = p * 2;
    case (c)
      4'd0: model = a + b;
      4'd1: model = a - b;
      4'd2: model = a & b;
      4'd3: model = a | b;
      4'd4: model = a ^ b;
      4'd5: begin q = {32'd0, a} * p; model = q[31:0]; end
      4'd6: begin q = {32'd0, a} / p; model = q[31:0]; end
      4'd7: begin
        if (a[31]) begin
          q = {32'd0, ~a} / p;
          model = ~q[31:0];
        end else begin
          q = {32'd0, a} / p;
          model = q[31:0];
        end
      end
      4'd8: model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: model = (a < b) ? 32'd1 : 32'd0;
      default: model = 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    in_valid = 1'b1;
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    in_rd    = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    issue(4'd0, 32'd3, 32'd4, 5'd5);
    step();
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if (out_result !== 32'd0) $display("FAIL reset_result: got %h want 0", out_result);
    else passed++;
    total++;
    if (out_rd !== 5'd0 || out_zero !== 1'b0)
      $display("FAIL reset_rd_zero: got rd=%0d z=%b want 0/0", out_rd, out_zero);
    else passed++;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] e [4];
    logic [4:0]  r [4];
    logic        z [4];
    c = '{4'd0, 4'd1, 4'd9, 4'd1};
    a = '{32'd5, 32'd5, 32'd1, 32'd9};
    b = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'd9};
    e = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0};
    r = '{5'd3, 5'd4, 5'd5, 5'd6};
    z = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(c[i], a[i], b[i], r[i]);
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
      else passed++;
      step();
      total++;
      if (out_valid !== 1'b1 || out_result !== e[i] || out_rd !== r[i] || out_zero !== z[i])
        $display("FAIL b2b_%0d: got v=%b %h rd=%0d z=%b want 1 %h rd=%0d z=%b",
                 i, out_valid, out_result, out_rd, out_zero, 1'b1, e[i], r[i], z[i]);
      else passed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_shift_sra();
    issue(4'd7, 32'h80000000, 32'h00000024, 5'd7);
    step();
    in_valid = 1'b0;
`ifdef SERIAL_SHIFT_EN
    for (int k = 1; k < 5; k++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL sra_busy%0d: got rdy=%b v=%b want 0/0", k, in_ready, out_valid);
      else passed++;
      step();
    end
`endif
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'hF8000000 || out_rd !== 5'd7)
      $display("FAIL sra_result: got v=%b %h rd=%0d want 1 f8000000 rd=7",
               out_valid, out_result, out_rd);
    else passed++;
  endtask

  task automatic test_stall();
    issue(4'd0, 32'h1000, 32'h0234, 5'd9);
    step();
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'h1234)
      $display("FAIL stall_pre: got v=%b %h want 1 1234", out_valid, out_result);
    else passed++;
    stall = 1'b1;
    issue(4'd0, 32'd1, 32'd1, 5'd10);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", k, in_ready);
      else passed++;
      step();
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h1234 || out_rd !== 5'd9)
        $display("FAIL stall_hold%0d: got v=%b %h rd=%0d want 1 1234 rd=9",
                 k, out_valid, out_result, out_rd);
      else passed++;
    end
    stall = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL stall_release: got %b want 1", in_ready);
    else passed++;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'd2 || out_rd !== 5'd10)
      $display("FAIL stall_next: got v=%b %h rd=%0d want 1 2 rd=10",
               out_valid, out_result, out_rd);
    else passed++;
  endtask

  task automatic test_flush();
    bit stale;
    issue(4'd0, 32'd2, 32'd2, 5'd1);
    step();
    stall = 1'b1;
    flush = 1'b1;
    issue(4'd0, 32'd7, 32'd7, 5'd2);
    #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", in_ready);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_over_stall: got %b want 0", out_valid);
    else passed++;
    stall = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_no_accept: got %b want 0", out_valid);
    else passed++;
`ifdef SERIAL_SHIFT_EN
    issue(4'd5, 32'd1, 32'd31, 5'd3);
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_shift: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    else passed++;
    stale = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    total++;
    if (stale !== 1'b0) $display("FAIL flush_stale: got %b want 0", stale);
    else passed++;
`else
    stale = 1'b0;
`endif
  endtask

  task automatic test_reserved();
    issue(4'hF, 32'hFFFFFFFF, $urandom, 5'd17);
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1 || out_rd !== 5'd17)
      $display("FAIL reserved: got v=%b %h z=%b rd=%0d want 1 0 1 rd=17",
               out_valid, out_result, out_zero, out_rd);
    else passed++;
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    logic [4:0]  r;
    int lat;
    int n;
    for (int i = 0; i < 150; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      r = 5'($urandom);
      if (i % 10 == 0) a = 32'h80000000;
      if (i % 10 == 1) b = 32'hFFFFFFFF;
      if (i % 10 == 2) b = a;
      e = model(c, a, b);
      lat = 1;
`ifdef SERIAL_SHIFT_EN
      if ((c == 4'd5 || c == 4'd6 || c == 4'd7) && b[4:0] != 5'd0)
        lat = int'(b[4:0]) + 1;
`endif
      issue(c, a, b, r);
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL rnd_ready%0d: got %b want 1", i, in_ready);
      else passed++;
      step();
      in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      total++;
      if (out_valid !== 1'b1 || n != lat)
        $display("FAIL rnd_lat%0d: got v=%b lat=%0d want 1 lat=%0d", i, out_valid, n, lat);
      else passed++;
      total++;
      if (out_result !== e || out_rd !== r || out_zero !== (e == 32'd0))
        $display("FAIL rnd_res%0d: ctrl=%0d a=%h b=%h got %h rd=%0d z=%b want %h rd=%0d",
                 i, c, a, b, out_result, out_rd, out_zero, e, r);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shift_sra();
    step();
    test_stall();
    step();
    test_flush();
    test_reserved();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
